// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronized row sampling
// once per column dwell, press/release debounce and a registered key report.
module keypad_scan #(
  parameter int BW  = 19,
  parameter int DBN = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [BW-1:0] TIMEOUT,
  input  logic [3:0]    ROW,
  output logic [3:0]    COL_SEL,
  output logic [3:0]    KEY_CODE,
  output logic          KEY_VALID,
  output logic          KEY_HELD
);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [3:0] DBN_C = 4'(DBN);

  // Lowest-index active-low row; only meaningful when some row is low.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] c);
    logic [3:0] oh;
    case (c)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

  logic [3:0]    sync1_r, rs_r;
  logic [BW-1:0] timer_r, timer_nx_s;
  state_t        state_r, state_nx_s;
  logic [1:0]    col_r, col_nx_s, prow_r, prow_nx_s, pcol_r, pcol_nx_s;
  logic [3:0]    mcnt_r, mcnt_nx_s, rcnt_r, rcnt_nx_s;
  logic [3:0]    col_sel_r, key_code_r, key_code_nx_s;
  logic          key_valid_r, key_valid_nx_s, key_held_r, key_held_nx_s;
  logic          smp_s, all_high_s;
  logic [1:0]    low_s;

  assign smp_s      = (timer_r == TIMEOUT);
  assign all_high_s = (rs_r == 4'hF);
  assign low_s      = low_row(rs_r);

  // Next-state, dwell timer and output decode.
  always_comb begin
    timer_nx_s     = smp_s ? {BW{1'b0}} : timer_r + BW'(1);
    state_nx_s     = state_r;
    col_nx_s       = col_r;
    prow_nx_s      = prow_r;
    pcol_nx_s      = pcol_r;
    mcnt_nx_s      = mcnt_r;
    rcnt_nx_s      = rcnt_r;
    key_code_nx_s  = key_code_r;
    key_valid_nx_s = 1'b0;
    key_held_nx_s  = key_held_r;
    case (state_r)
      SCAN: begin
        if (smp_s) begin
          if (all_high_s) begin
            col_nx_s = col_r + 2'd1;
          end else begin
            prow_nx_s = low_s;
            pcol_nx_s = col_r;
            mcnt_nx_s = 4'd1;
            rcnt_nx_s = 4'd0;
            // A single required match confirms on the detect strobe itself.
            if (DBN_C == 4'd1) begin
              key_code_nx_s  = {low_s, col_r};
              key_valid_nx_s = 1'b1;
              key_held_nx_s  = 1'b1;
              state_nx_s     = HELD;
            end else begin
              state_nx_s = CONFIRM;
            end
          end
        end else begin
          state_nx_s = SCAN;
        end
      end
      CONFIRM: begin
        if (smp_s) begin
          if (!all_high_s && (low_s == prow_r)) begin
            mcnt_nx_s = mcnt_r + 4'd1;
            if ((mcnt_r + 4'd1) == DBN_C) begin
              key_code_nx_s  = {prow_r, pcol_r};
              key_valid_nx_s = 1'b1;
              key_held_nx_s  = 1'b1;
              rcnt_nx_s      = 4'd0;
              state_nx_s     = HELD;
            end else begin
              state_nx_s = CONFIRM;
            end
          end else begin
            col_nx_s   = col_r + 2'd1;
            state_nx_s = SCAN;
          end
        end else begin
          state_nx_s = CONFIRM;
        end
      end
      HELD: begin
        if (smp_s) begin
          if (rs_r[prow_r]) begin
            rcnt_nx_s = rcnt_r + 4'd1;
            if ((rcnt_r + 4'd1) == DBN_C) begin
              key_held_nx_s = 1'b0;
              col_nx_s      = col_r + 2'd1;
              rcnt_nx_s     = 4'd0;
              state_nx_s    = SCAN;
            end else begin
              state_nx_s = HELD;
            end
          end else begin
            rcnt_nx_s = 4'd0;
          end
        end else begin
          state_nx_s = HELD;
        end
      end
      default: begin
        state_nx_s = SCAN;
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r     <= 4'hF;
      rs_r        <= 4'hF;
      timer_r     <= {BW{1'b0}};
      state_r     <= SCAN;
      col_r       <= 2'd0;
      prow_r      <= 2'd0;
      pcol_r      <= 2'd0;
      mcnt_r      <= 4'd0;
      rcnt_r      <= 4'd0;
      col_sel_r   <= 4'b0001;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      sync1_r     <= ROW;
      rs_r        <= sync1_r;
      timer_r     <= timer_nx_s;
      state_r     <= state_nx_s;
      col_r       <= col_nx_s;
      prow_r      <= prow_nx_s;
      pcol_r      <= pcol_nx_s;
      mcnt_r      <= mcnt_nx_s;
      rcnt_r      <= rcnt_nx_s;
      col_sel_r   <= one_hot(col_nx_s);
      key_code_r  <= key_code_nx_s;
      key_valid_r <= key_valid_nx_s;
      key_held_r  <= key_held_nx_s;
    end
  end

  assign COL_SEL   = col_sel_r;
  assign KEY_CODE  = key_code_r;
  assign KEY_VALID = key_valid_r;
  assign KEY_HELD  = key_held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: two instances (DBN=3 and DBN=1) driven by keypad matrix
// models; a monitor scores every KEY_VALID pulse against queued expected codes.
module tb_keypad_scan;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [18:0] timeout = 19'd3;
  logic [3:0]  row_a, row_b, col_sel_a, col_sel_b, code_a, code_b;
  logic        valid_a, valid_b, held_a, held_b;
  logic [3:0]  keys_a [4];
  logic [3:0]  keys_b [4];
  logic        prev_a = 1'b0, prev_b = 1'b0;
  logic [3:0]  q_a [$];
  logic [3:0]  q_b [$];
  int          checks = 0, errors = 0, t = 0;

  always #5 CLK = ~CLK;

  keypad_scan #(.BW(19), .DBN(3)) dut_a (
    .CLK(CLK), .RST(RST), .TIMEOUT(timeout), .ROW(row_a),
    .COL_SEL(col_sel_a), .KEY_CODE(code_a), .KEY_VALID(valid_a), .KEY_HELD(held_a)
  );

  keypad_scan #(.BW(19), .DBN(1)) dut_b (
    .CLK(CLK), .RST(RST), .TIMEOUT(timeout), .ROW(row_b),
    .COL_SEL(col_sel_b), .KEY_CODE(code_b), .KEY_VALID(valid_b), .KEY_HELD(held_b)
  );

  // A pressed key pulls its row low only while its column is driven.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_a[r] = ~|(keys_a[r] & col_sel_a);
      row_b[r] = ~|(keys_b[r] & col_sel_b);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  // Scoreboard monitor: every KEY_VALID pulse must match a queued expectation.
  always @(negedge CLK) begin
    if (valid_a) begin
      check("valid_a_not_back_to_back", int'(prev_a), 0);
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_a: actual code %0d required no pulse (t=%0d)", code_a, t);
      end else begin
        check("code_a", int'(code_a), int'(q_a.pop_front()));
      end
    end
    if (valid_b) begin
      check("valid_b_not_back_to_back", int'(prev_b), 0);
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_b: actual code %0d required no pulse (t=%0d)", code_b, t);
      end else begin
        check("code_b", int'(code_b), int'(q_b.pop_front()));
      end
    end
    prev_a <= valid_a;
    prev_b <= valid_b;
  end

  task automatic tick();
    @(negedge CLK);
    t++;
  endtask

  task automatic goto(input int k);
    while (t < k) tick();
  endtask

  task automatic wait_valid(input bit use_b, input int exp_t);
    int n = 0;
    while (!(use_b ? valid_b : valid_a) && n < 40) begin
      tick();
      n++;
    end
    if (!(use_b ? valid_b : valid_a)) begin
      checks++; errors++;
      $display("FAIL valid_timeout: actual none required pulse at t=%0d", exp_t);
    end else begin
      check(use_b ? "latency_b" : "latency_a", t, exp_t);
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin
      keys_a[r] = 4'h0;
      keys_b[r] = 4'h0;
    end
    repeat (3) @(negedge CLK);
    check("reset_col_sel", int'(col_sel_a), 1);
    check("reset_code", int'(code_a), 0);
    check("reset_valid", int'(valid_a), 0);
    check("reset_held", int'(held_a), 0);
    check("reset_col_sel_b", int'(col_sel_b), 1);
    RST = 1'b0;
    t = 0;

    // Idle scan: each column held for 4 clocks.
    for (int i = 0; i < 20; i++) begin
      goto(i);
      check("idle_col_sel", int'(col_sel_a), 1 << ((i / 4) % 4));
    end

    // Press row 2 in column 1.
    goto(20);
    q_a.push_back(4'b1001);
    keys_a[2] = 4'b0010;
    wait_valid(1'b0, 32);
    goto(36);
    check("press_held", int'(held_a), 1);
    check("press_col_hold", int'(col_sel_a), 4'b0010);

    // Release with a one-sample glitch that restarts the release count.
    goto(40);
    keys_a[2] = 4'b0000;
    goto(48);
    keys_a[2] = 4'b0010;
    goto(52);
    keys_a[2] = 4'b0000;
    goto(60);
    check("release_glitch_held", int'(held_a), 1);
    goto(63);
    check("release_last_held", int'(held_a), 1);
    goto(64);
    check("release_held_fall", int'(held_a), 0);
    check("release_col_next", int'(col_sel_a), 4'b0100);

    // Bounce: row 0 low for one sample in column 3.
    goto(68);
    keys_a[0] = 4'b1000;
    goto(72);
    keys_a[0] = 4'b0000;
    check("bounce_confirm_hold", int'(col_sel_a), 4'b1000);
    goto(76);
    check("bounce_back_scan", int'(col_sel_a), 4'b0001);

    // Alternating low/high on row 1 in column 1 never confirms.
    goto(80);
    keys_a[1] = 4'b0010;
    goto(84);
    keys_a[1] = 4'b0000;
    goto(88);
    check("alt_col_advance1", int'(col_sel_a), 4'b0100);
    goto(100);
    keys_a[1] = 4'b0010;
    goto(104);
    keys_a[1] = 4'b0000;
    goto(108);
    check("alt_col_advance2", int'(col_sel_a), 4'b0100);
    check("alt_not_held", int'(held_a), 0);

    // Multi-key: rows 3 and 1 in column 0; the lowest row wins.
    goto(116);
    q_a.push_back(4'b0100);
    keys_a[3] = 4'b0001;
    keys_a[1] = 4'b0001;
    wait_valid(1'b0, 128);
    goto(132);
    keys_a[2] = 4'b0100;
    keys_a[0] = 4'b0001;
    goto(140);
    check("multi_col_hold", int'(col_sel_a), 4'b0001);
    check("multi_held", int'(held_a), 1);
    check("multi_code_kept", int'(code_a), 4'b0100);
    for (int r = 0; r < 4; r++) keys_a[r] = 4'h0;
    goto(152);
    check("multi_release", int'(held_a), 0);
    check("multi_col_next", int'(col_sel_a), 4'b0010);

    // Reset in the middle of CONFIRM.
    keys_a[2] = 4'b0010;
    goto(156);
    check("rst_confirm_entered", int'(col_sel_a), 4'b0010);
    goto(158);
    RST = 1'b1;
    keys_a[2] = 4'b0000;
    goto(160);
    RST = 1'b0;
    check("rst_col_sel", int'(col_sel_a), 4'b0001);
    check("rst_held", int'(held_a), 0);
    check("rst_valid", int'(valid_a), 0);
    goto(164);
    check("rst_resume_scan", int'(col_sel_a), 4'b0010);

    // DBN=1 instance confirms on its first sample.
    goto(168);
    q_b.push_back(4'b1110);
    keys_b[3] = 4'b0100;
    wait_valid(1'b1, 172);
    goto(176);
    check("dbn1_held", int'(held_b), 1);
    check("dbn1_col_hold", int'(col_sel_b), 4'b0100);
    keys_b[3] = 4'b0000;
    goto(180);
    check("dbn1_release", int'(held_b), 0);
    check("dbn1_col_next", int'(col_sel_b), 4'b1000);

    goto(190);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter BW, default 19: width of the per-column dwell timer and of TIMEOUT.
REQ-002 Parameter DBN, default 3: number of consecutive matching samples needed to confirm a press or a release; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 TIMEOUT  input  BW  column dwell length minus one; quasi-static; legal values >= 2.
REQ-006 ROW  input  4  keypad row lines, active-low (pulled up externally), asynchronous to CLK.
REQ-007 COL_SEL  output  4  one-hot column drive enable, active-high; the top level converts it to tristate drive.
REQ-008 KEY_CODE  output  4  {row index[1:0], column index[1:0]} of the last confirmed key.
REQ-009 KEY_VALID  output  1  one-cycle pulse when a press is confirmed.
REQ-010 KEY_HELD  output  1  high from the confirm cycle until the release is confirmed.

Function
REQ-011 ROW shall pass through a 2-flop synchronizer; all decisions shall use the synchronized value (rs).
REQ-012 The dwell timer shall count 0..TIMEOUT and then wrap to 0; the sample strobe (smp) is the cycle in which timer == TIMEOUT.
- Dwell per column is TIMEOUT+1 clocks.
REQ-013 The column index (col) shall take effect on COL_SEL as a one-hot output: col 0 -> 4'b0001 ... col 3 -> 4'b1000.
REQ-014 The FSM shall have three states: SCAN, CONFIRM and HELD.
REQ-015 SCAN, on smp with rs == 4'hF: col shall advance as 0->1->2->3->0, and the timer shall restart.
REQ-016 SCAN, on smp with any rs bit low:
- latch the lowest-index low row as prow and latch col as pcol;
- clear the match counter (mcnt) to 1;
- go to CONFIRM; col is held.
REQ-017 CONFIRM, on smp where the lowest low row equals prow: mcnt shall increment.
- When mcnt reaches DBN, in that same cycle: KEY_CODE <= {prow, pcol}, KEY_VALID = 1 for exactly one clock, KEY_HELD <= 1, and the state goes to HELD.
- With DBN = 1 the confirm shall happen on the SCAN detect strobe itself, skipping CONFIRM.
REQ-018 CONFIRM, on smp where rs == 4'hF or a different lowest row is low: return to SCAN, with col advancing to the next column, and no output change.
REQ-019 HELD: col is held and the release counter (rcnt) counts consecutive smp with rs[prow] high.
- Any smp with rs[prow] low clears rcnt.
- When rcnt reaches DBN: KEY_HELD <= 0, go to SCAN, col advances to the next column.
REQ-020 While in CONFIRM or HELD, other keys in the same column and all keys in other columns shall be ignored; no second KEY_VALID is produced until HELD has been exited.
REQ-021 KEY_CODE shall hold its value until the next confirm.
REQ-022 KEY_VALID shall never be asserted on two consecutive cycles.
REQ-023 Outputs shall be registered: no combinational path from ROW to any output.
REQ-024 Between the first smp that sees a low row and KEY_VALID: (DBN-1)*(TIMEOUT+1) clocks plus 1 register clock.
REQ-025 TIMEOUT changing mid-dwell shall take effect at the next wrap or compare; behaviour for TIMEOUT < 2 is undefined, since synchronizer latency makes the sampled row stale.

Reset
REQ-026 With RST high at a clock edge, on that edge:
- COL_SEL = 4'b0001, KEY_CODE = 4'h0, KEY_VALID = 0, KEY_HELD = 0;
- state = SCAN, timer = 0, mcnt = rcnt = 0;
- synchronizer flops = 4'hF.
REQ-027 Reset asserted in any state, including mid-CONFIRM or mid-HELD, shall abort with no KEY_VALID pulse; scanning shall resume at col 0 on the first clock after RST falls.

Verification (TIMEOUT = 3, DBN = 3 unless noted)
REQ-028 Idle: RST released, ROW = 4'hF.
- COL_SEL sequence is 0001, 0010, 0100, 1000, 0001, each held 4 clocks.
- KEY_VALID never asserts.
REQ-029 Press: ROW[2] held low while COL_SEL = 0010.
- Exactly one KEY_VALID pulse with KEY_CODE = 4'b1001; KEY_HELD = 1.
- COL_SEL stays 0010 while the key is held.
REQ-030 Bounce: ROW[0] low for 1 sample at col 3, then high.
- Returns to SCAN, COL_SEL advances to 0001, no KEY_VALID.
- An alternating low/high pattern on ROW[1] likewise never confirms.
REQ-031 Release: after REQ-029, ROW goes to 4'hF.
- KEY_HELD falls after 3 consecutive high samples, then COL_SEL = 0100.
- A single low glitch during the release count restarts the count.
REQ-032 Multi-key: ROW[3] and ROW[1] low together at col 0 gives KEY_CODE = 4'b0100.
- A second key pressed in col 2 while HELD is ignored.
REQ-033 Reset mid-operation: RST pulsed during CONFIRM gives no KEY_VALID, KEY_HELD = 0, COL_SEL = 0001.
- With DBN = 1, a press confirms on its first sample.
